instr_fetch_unit: RTL and testbench

Instruction fetch stage and IF/ID pipeline register for the MIPS core. Maintains the PC and fetches one 32-bit word per request from instruction memory over a req/ack handshake. Holds the fetched word in IF/ID and drives `opcode` directly into the control unit. Accepts branch/jump redirects and a decode stall, and discards any fetch that was in flight when a redirect arrived.

---
 rtl/instr_fetch_unit.sv | 69 ++++++
 tb/tb_instr_fetch_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, req/ack instruction fetch and IF/ID register with redirect and stall handling
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        pc_src,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus4,
  output logic [5:0]  opcode
);
  typedef enum logic [1:0] {REQ, FULL, DROP} state_t;
  state_t state;
  logic [31:0] pc, stale_addr, buf_instr, buf_pc4, pc_plus4, target;
  logic ack, accept, redirect;
  assign pc_plus4 = pc + 32'd4;
  assign accept = !if_valid || !stall;
  assign redirect = jump || pc_src;
  assign target = jump ? {if_pc_plus4[31:28], jump_index, 2'b00} : branch_target;
  assign imem_req = rst_n && (state != FULL);
  assign imem_addr = (state == DROP) ? stale_addr : pc;
  assign ack = imem_ack && (state != FULL);
  assign opcode = if_instr[31:26];
  // fetch sequencing; a redirect flushes IF/ID and, if a fetch is still in flight, parks in DROP to swallow it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= REQ;
      pc <= RESET_PC;
      stale_addr <= '0;
      buf_instr <= '0;
      buf_pc4 <= '0;
      {if_valid, if_instr, if_pc_plus4} <= '0;
    end else if (redirect) begin
      pc <= target;
      {if_valid, if_instr, if_pc_plus4} <= '0;
      if (state == REQ && !ack) begin
        stale_addr <= pc;
        state <= DROP;
      end else if (state != DROP || ack) state <= REQ;
    end else
      case (state)
        REQ:
          if (ack) begin
            pc <= pc_plus4;
            if (accept) {if_valid, if_instr, if_pc_plus4} <= {1'b1, imem_rdata, pc_plus4};
            else begin
              buf_instr <= imem_rdata;
              buf_pc4 <= pc_plus4;
              state <= FULL;
            end
          end else if (accept) {if_valid, if_instr, if_pc_plus4} <= '0;
        FULL:
          if (!stall) begin
            {if_valid, if_instr, if_pc_plus4} <= {1'b1, buf_instr, buf_pc4};
            state <= REQ;
          end
        DROP: if (ack) state <= REQ;
        default: state <= REQ;
      endcase
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and randomized checks of instr_fetch_unit against a queue-based fetch model
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic stall = 1'b0, pc_src = 1'b0, jump = 1'b0, imem_ack = 1'b0;
  logic [31:0] branch_target = '0;
  logic [25:0] jump_index = '0;
  logic [31:0] imem_rdata, imem_addr, if_instr, if_pc_plus4;
  logic imem_req, if_valid;
  logic [5:0] opcode;
  int passed = 0, total = 0;
  int lat = 0, cnt = 0;
  bit rnd_lat = 1'b0;
  logic [31:0] m_pc, m_drop_addr, m_instr, m_pc4;
  bit m_drop, m_v;
  logic [63:0] m_buf[$];

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
    .jump(jump), .jump_index(jump_index), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc_plus4(if_pc_plus4), .opcode(opcode)
  );

  // free-running clock
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000 + {2'b00, a[31:2]};
  endfunction
  assign imem_rdata = mem_word(imem_addr);

  function automatic bit m_req();
    return rst_n && m_buf.size() == 0;
  endfunction
  function automatic logic [31:0] m_addr();
    return m_drop ? m_drop_addr : m_pc;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic set_ifid(input bit v, input logic [31:0] ins, input logic [31:0] p4);
    m_v = v;
    m_instr = ins;
    m_pc4 = p4;
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_drop = 1'b0;
    m_drop_addr = '0;
    m_buf.delete();
    set_ifid(1'b0, '0, '0);
  endtask

  task automatic model_step();
    bit ack, take;
    logic [31:0] tgt;
    ack = imem_ack && m_req();
    take = !m_v || !stall;
    if (jump || pc_src) begin
      tgt = jump ? {m_pc4[31:28], jump_index, 2'b00} : branch_target;
      if (m_buf.size() == 0) begin
        if (m_drop) begin
          if (ack) m_drop = 1'b0;
        end else if (!ack) begin
          m_drop = 1'b1;
          m_drop_addr = m_pc;
        end
      end
      m_buf.delete();
      m_pc = tgt;
      set_ifid(1'b0, '0, '0);
    end else if (m_buf.size() != 0) begin
      if (!stall) begin
        set_ifid(1'b1, m_buf[0][63:32], m_buf[0][31:0]);
        m_buf.delete();
      end
    end else if (m_drop) begin
      if (ack) m_drop = 1'b0;
      if (take) set_ifid(1'b0, '0, '0);
    end else if (ack) begin
      if (take) set_ifid(1'b1, mem_word(m_pc), m_pc + 32'd4);
      else m_buf.push_back({mem_word(m_pc), m_pc + 32'd4});
      m_pc = m_pc + 32'd4;
    end else if (take) set_ifid(1'b0, '0, '0);
  endtask

  task automatic drive_ack();
    if (!m_req()) begin
      cnt = 0;
      imem_ack = 1'b0;
    end else begin
      imem_ack = cnt >= lat;
      cnt = imem_ack ? 0 : cnt + 1;
      if (imem_ack && rnd_lat) lat = $urandom_range(0, 2);
    end
  endtask

  task automatic compare_all();
    chk("imem_req", imem_req, m_req());
    if (m_req()) chk("imem_addr", imem_addr, m_addr());
    chk("if_valid", if_valid, m_v);
    chk("if_instr", if_instr, m_instr);
    chk("if_pc_plus4", if_pc_plus4, m_pc4);
    chk("opcode", opcode, m_instr[31:26]);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #2;
    drive_ack();
    @(negedge clk);
    compare_all();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 drive_ack();
    @(negedge clk);
    compare_all();
    chk("rel_req", imem_req, 1);
    chk("rel_addr", imem_addr, 32'h0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    chk("rst_req", imem_req, 0);
    chk("rst_valid", if_valid, 0);
    release_reset();
    tick();
    chk("seq_addr4", imem_addr, 32'h4);
    chk("first_instr", if_instr, 32'h1000);
    chk("first_pc4", if_pc_plus4, 32'h4);
    tick();
    chk("seq_addr8", imem_addr, 32'h8);
    stall = 1'b1;
    tick();
    chk("stall_req", imem_req, 0);
    chk("stall_hold", if_instr, 32'h1001);
    tick();
    chk("stall_hold_pc4", if_pc_plus4, 32'h8);
    stall = 1'b0;
    lat = 2;
    tick();
    chk("unstall_instr", if_instr, 32'h1002);
    chk("unstall_pc4", if_pc_plus4, 32'hC);
    chk("unstall_addr", imem_addr, 32'hC);
    repeat (3) tick();
    chk("slow_addr", imem_addr, 32'h10);
    pc_src = 1'b1;
    branch_target = 32'h40;
    tick();
    pc_src = 1'b0;
    chk("drop_addr", imem_addr, 32'h10);
    chk("drop_valid", if_valid, 0);
    chk("drop_opcode", opcode, 0);
    tick();
    chk("drop_addr_hold", imem_addr, 32'h10);
    repeat (3) begin
      tick();
      chk("br_addr", imem_addr, 32'h40);
      chk("br_valid", if_valid, 0);
    end
    tick();
    chk("br_instr", if_instr, 32'h1010);
    chk("br_pc4", if_pc_plus4, 32'h44);
    pc_src = 1'b1;
    branch_target = 32'h1000_000C;
    lat = 0;
    tick();
    pc_src = 1'b0;
    tick();
    chk("far_addr", imem_addr, 32'h1000_000C);
    tick();
    chk("far_pc4", if_pc_plus4, 32'h1000_0010);
    chk("far_opcode", opcode, 6'd1);
    stall = 1'b1;
    tick();
    chk("full_req", imem_req, 0);
    jump = 1'b1;
    jump_index = 26'h10;
    pc_src = 1'b1;
    branch_target = 32'h80;
    tick();
    jump = 1'b0;
    pc_src = 1'b0;
    stall = 1'b0;
    chk("jump_addr", imem_addr, 32'h1000_0040);
    chk("jump_flush", if_valid, 0);
    chk("jump_instr", if_instr, 32'h0);
    tick();
    chk("jump_pc4", if_pc_plus4, 32'h1000_0044);
    chk("jump_word", if_instr, 32'h0400_1010);
    pc_src = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    tick();
    pc_src = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc4", if_pc_plus4, 32'h0);
    chk("wrap_next", imem_addr, 32'h0);
    lat = 2;
    tick();
    pc_src = 1'b1;
    branch_target = 32'h200;
    tick();
    pc_src = 1'b0;
    chk("mid_drop_req", imem_req, 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_req", imem_req, 0);
    chk("async_valid", if_valid, 0);
    chk("async_instr", if_instr, 32'h0);
    tick();
    lat = 0;
    release_reset();
    tick();
    stall = 1'b1;
    tick();
    chk("full_valid", if_valid, 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_full_valid", if_valid, 0);
    chk("async_full_instr", if_instr, 32'h0);
    stall = 1'b0;
    tick();
    release_reset();
    rnd_lat = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      int r;
      tick();
      r = $urandom_range(0, 99);
      stall = $urandom_range(0, 9) < 3;
      pc_src = r < 6;
      jump = r >= 4 && r < 9;
      branch_target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      jump_index = 26'($urandom());
    end
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
